// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if -- hazard detection signal bundle between the
// pipeline datapath and the hazard control unit.
//   master : pipeline side; drives ID/EX/MEM status, receives stage controls
//   slave  : hazard unit side; reads status, drives controls and counters
// Status : id_rs1/id_rs2, id_uses_rs1/id_uses_rs2, ex_mem_read, ex_rd,
//          branch_taken, mem_req, mem_ready
// Control: pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush
// Perf   : stall_cycles, flush_cycles (16-bit)
interface hazard_control_unit_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [15:0]      stall_cycles;
  logic [15:0]      flush_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush,
           stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit -- pipeline stall/flush controller.
// Resolves memory stalls, taken-branch flushes and load-use hazards
// (priority in that order) into PC / pipeline-register enables and bubble
// inserts. State updates on the falling clock edge, matching the pipeline
// registers; control outputs are combinational from state and inputs.
// Ports:
//   clk   : clock (state changes on negedge)
//   reset : asynchronous active-low reset
//   hz    : hazard_control_unit_if.slave bundle (status in, controls out)
// Parameters: REG_W register-index width; BR_PENALTY (1..3) IF/ID flush
//   cycles per taken branch.
// Build option: define HAZARD_PERF_CNT_EN to implement the saturating
//   stall_cycles / flush_cycles counters; otherwise both read constant 0.
module hazard_control_unit #(
  parameter int REG_W      = 5,
  parameter int BR_PENALTY = 1
) (
  input logic                  clk,
  input logic                  reset,
  hazard_control_unit_if.slave hz
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;     // IF/ID flush cycles still owed
  logic [REG_W-1:0] rd;
  logic             mem_stall, load_use, flushing;
  logic             pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush;

  assign rd        = hz.ex_rd;
  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign load_use  = hz.ex_mem_read && (rd != '0) &&
                     ((hz.id_uses_rs1 && hz.id_rs1 == rd) ||
                      (hz.id_uses_rs2 && hz.id_rs2 == rd));
  // cnt_q is only nonzero in FLUSH, or in MEM_WAIT entered from FLUSH, so
  // it alone says whether this cycle continues a branch flush.
  assign flushing  = (cnt_q != 2'd0);

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    ex_mem_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (!reset) begin
      // everything frozen while held in reset
    end else if (mem_stall) begin
      state_d = MEM_WAIT;             // cnt_q held so a flush resumes later
    end else if (flushing) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      ex_mem_en   = 1'b1;
      if_id_flush = 1'b1;
      cnt_d       = cnt_q - 2'd1;
      state_d     = (cnt_q == 2'd1) ? RUN : FLUSH;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      ex_mem_en = 1'b1;
      state_d   = RUN;
      if (hz.branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (BR_PENALTY > 1) begin
          state_d = FLUSH;
          cnt_d   = 2'(BR_PENALTY - 1);
        end
      end else if (load_use) begin
        // hold PC and IF/ID one cycle, bubble into EX; the load moves on
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.if_id_en    = if_id_en;
  assign hz.ex_mem_en   = ex_mem_en;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;

  // pc_en is forced low in reset, but the counters are cleared there anyway
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!pc_en && stall_q != 16'hFFFF)      stall_q <= stall_q + 16'd1;
      if (if_id_flush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_cycles = flush_q;
`else
  assign hz.stall_cycles = 16'd0;
  assign hz.flush_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit -- directed-vector bench for hazard_control_unit.
// Two instances share the stimulus: d3 (BR_PENALTY=3) and d1 (BR_PENALTY=1).
// Control outputs are compared as {pc_en,if_id_en,ex_mem_en,if_id_flush,
// id_ex_flush}. Inputs change just after a rising edge and outputs are
// sampled 1 ns later, well before the falling edge that commits state.
module tb_hazard_control_unit;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic       branch_taken, mem_req, mem_ready;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit_if #(.REG_W(5)) bus3();
  hazard_control_unit_if #(.REG_W(5)) bus1();

  assign bus3.id_rs1 = id_rs1;            assign bus1.id_rs1 = id_rs1;
  assign bus3.id_rs2 = id_rs2;            assign bus1.id_rs2 = id_rs2;
  assign bus3.id_uses_rs1 = id_uses_rs1;  assign bus1.id_uses_rs1 = id_uses_rs1;
  assign bus3.id_uses_rs2 = id_uses_rs2;  assign bus1.id_uses_rs2 = id_uses_rs2;
  assign bus3.ex_mem_read = ex_mem_read;  assign bus1.ex_mem_read = ex_mem_read;
  assign bus3.ex_rd = ex_rd;              assign bus1.ex_rd = ex_rd;
  assign bus3.branch_taken = branch_taken; assign bus1.branch_taken = branch_taken;
  assign bus3.mem_req = mem_req;          assign bus1.mem_req = mem_req;
  assign bus3.mem_ready = mem_ready;      assign bus1.mem_ready = mem_ready;

  hazard_control_unit #(.REG_W(5), .BR_PENALTY(3)) u_d3 (
    .clk(clk), .reset(reset), .hz(bus3));
  hazard_control_unit #(.REG_W(5), .BR_PENALTY(1)) u_d1 (
    .clk(clk), .reset(reset), .hz(bus1));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] e3,
                         input logic [4:0] e1);
    chk({tag, "_d3"}, {27'd0, bus3.pc_en, bus3.if_id_en, bus3.ex_mem_en,
                       bus3.if_id_flush, bus3.id_ex_flush}, {27'd0, e3});
    chk({tag, "_d1"}, {27'd0, bus1.pc_en, bus1.if_id_en, bus1.ex_mem_en,
                       bus1.if_id_flush, bus1.id_ex_flush}, {27'd0, e1});
  endtask

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk_cnt(input string tag, input int s, input int f3,
                         input int f1);
    chk({tag, "_stall3"}, {16'd0, bus3.stall_cycles}, cnt(s));
    chk({tag, "_stall1"}, {16'd0, bus1.stall_cycles}, cnt(s));
    chk({tag, "_flush3"}, {16'd0, bus3.flush_cycles}, cnt(f3));
    chk({tag, "_flush1"}, {16'd0, bus1.flush_cycles}, cnt(f1));
  endtask

  // one cycle of stimulus: branch, mem_req, mem_ready, ex_mem_read, ex_rd
  task automatic drv(input logic br, input logic rq, input logic rdy,
                     input logic lr, input logic [4:0] rd);
    @(posedge clk);
    branch_taken = br; mem_req = rq; mem_ready = rdy;
    ex_mem_read = lr;  ex_rd = rd;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    id_rs1 = 5'd3; id_rs2 = 5'd5; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_ctl("in_reset", 5'b00000, 5'b00000);
    chk_cnt("in_reset", 0, 0, 0);

    @(posedge clk); reset = 1'b1; #1;
    chk_ctl("idle", 5'b11100, 5'b11100);

    // load-use hazards
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    drv(0, 0, 1, 1, 5'd5); chk_ctl("lu_rs2", 5'b00101, 5'b00101);
    drv(0, 0, 1, 0, 5'd5); chk_ctl("lu_after", 5'b11100, 5'b11100);
    drv(0, 0, 1, 1, 5'd3); chk_ctl("lu_rs1", 5'b00101, 5'b00101);
    id_uses_rs1 = 1'b0;
    drv(0, 0, 1, 1, 5'd3); chk_ctl("lu_rs1_unused", 5'b11100, 5'b11100);
    id_rs2 = 5'd0;
    drv(0, 0, 1, 1, 5'd0); chk_ctl("lu_rd0", 5'b11100, 5'b11100);
    id_rs2 = 5'd5;
    chk_cnt("lu", 2, 0, 0);

    // branch pulse
    drv(1, 0, 1, 0, 0); chk_ctl("br_0", 5'b11111, 5'b11111);
    drv(0, 0, 1, 0, 0); chk_ctl("br_1", 5'b11110, 5'b11100);
    drv(0, 0, 1, 0, 0); chk_ctl("br_2", 5'b11110, 5'b11100);
    drv(0, 0, 1, 0, 0); chk_ctl("br_3", 5'b11100, 5'b11100);
    chk_cnt("br", 2, 3, 1);

    // branch held, load-use during flush: branch beats load-use in RUN
    drv(1, 0, 1, 0, 0);    chk_ctl("brh_0", 5'b11111, 5'b11111);
    drv(1, 0, 1, 1, 5'd5); chk_ctl("brh_1", 5'b11110, 5'b11111);
    drv(0, 0, 1, 0, 0);    chk_ctl("brh_2", 5'b11110, 5'b11100);
    drv(0, 0, 1, 0, 0);    chk_ctl("brh_3", 5'b11100, 5'b11100);
    chk_cnt("brh", 2, 6, 3);

    // memory stall with branch held, then completion
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 0, 1, 5'd5); chk_ctl("ms_frz", 5'b00000, 5'b00000);
    end
    drv(1, 1, 1, 0, 0); chk_ctl("ms_rdy", 5'b11111, 5'b11111);
    drv(0, 0, 1, 0, 0); chk_ctl("ms_f1", 5'b11110, 5'b11100);
    drv(0, 0, 1, 0, 0); chk_ctl("ms_f2", 5'b11110, 5'b11100);
    drv(0, 0, 1, 0, 0); chk_ctl("ms_end", 5'b11100, 5'b11100);
    chk_cnt("ms", 6, 9, 4);

    // memory stall in the middle of a flush holds the remaining count
    drv(1, 0, 1, 0, 0); chk_ctl("mf_br", 5'b11111, 5'b11111);
    drv(0, 1, 0, 0, 0); chk_ctl("mf_s1", 5'b00000, 5'b00000);
    drv(0, 1, 0, 0, 0); chk_ctl("mf_s2", 5'b00000, 5'b00000);
    drv(0, 1, 1, 0, 0); chk_ctl("mf_r1", 5'b11110, 5'b11100);
    drv(0, 0, 1, 0, 0); chk_ctl("mf_r2", 5'b11110, 5'b11100);
    drv(0, 0, 1, 0, 0); chk_ctl("mf_end", 5'b11100, 5'b11100);
    chk_cnt("mf", 8, 12, 5);

    // reset in the second flush cycle
    drv(1, 0, 1, 0, 0); chk_ctl("rf_br", 5'b11111, 5'b11111);
    drv(0, 0, 1, 0, 0); chk_ctl("rf_f1", 5'b11110, 5'b11100);
    @(posedge clk); reset = 1'b0; #1;
    chk_ctl("rf_rst", 5'b00000, 5'b00000);
    chk_cnt("rf_rst", 0, 0, 0);
    @(posedge clk); #1;
    chk_ctl("rf_hold", 5'b00000, 5'b00000);
    @(posedge clk); reset = 1'b1; #1;
    chk_ctl("rf_rel", 5'b11100, 5'b11100);
    drv(0, 0, 1, 0, 0); chk_ctl("rf_run", 5'b11100, 5'b11100);
    chk_cnt("rf_rel", 0, 0, 0);

    // reset during MEM_WAIT
    drv(0, 1, 0, 0, 0); chk_ctl("rm_s", 5'b00000, 5'b00000);
    @(posedge clk); reset = 1'b0; mem_req = 1'b0; mem_ready = 1'b1; #1;
    chk_ctl("rm_rst", 5'b00000, 5'b00000);
    @(posedge clk); reset = 1'b1; #1;
    chk_ctl("rm_rel", 5'b11100, 5'b11100);
    drv(0, 0, 1, 0, 0);
    chk_cnt("rm", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
